// File: rtl/borrow_skip_subtractor_seq.sv
// Sequential borrow-skip subtractor: diff = a - b - borrow_in, one BLOCK-bit slice per clock.
// Operands arrive and results leave over valid/ready handshakes.
module borrow_skip_subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      a,
    input  logic [WIDTH-1:0]                      b,
    input  logic                                  borrow_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH-1:0]                      diff,
    output logic                                  borrow_out,
    output logic                                  overflow,
    output logic [$clog2(WIDTH/BLOCK+1)-1:0]      skip_count
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int SCW  = $clog2(NBLK + 1);
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_overflow;
    logic [SCW-1:0]   r_skip_count;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [BLOCK-1:0] w_a_sl;
    logic [BLOCK-1:0] w_b_sl;
    logic [BLOCK+1:0] w_res;
    logic             w_skip;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_diff_next;

    // Ripple-borrow over one slice; the skip flag bypasses the chain when every bit pair is equal.
    function automatic logic [BLOCK+1:0] slice_sub(input logic [BLOCK-1:0] sa,
                                                   input logic [BLOCK-1:0] sb,
                                                   input logic             bin);
        logic [BLOCK:0]   br;
        logic [BLOCK-1:0] d;
        logic             skip;
        br    = {(BLOCK+1){1'b0}};
        d     = {BLOCK{1'b0}};
        br[0] = bin;
        for (int i = 0; i < BLOCK; i++) begin
            d[i]    = sa[i] ^ sb[i] ^ br[i];
            br[i+1] = (~sa[i] & sb[i]) | (~(sa[i] ^ sb[i]) & br[i]);
        end
        skip = (sa == sb);
        return {skip, (skip ? bin : br[BLOCK]), d};
    endfunction

    // Current slice operands, slice result and the merged result word.
    always_comb begin
        w_a_sl      = r_a[int'(r_k)*BLOCK +: BLOCK];
        w_b_sl      = r_b[int'(r_k)*BLOCK +: BLOCK];
        w_res       = slice_sub(w_a_sl, w_b_sl, r_br);
        w_skip      = w_res[BLOCK+1];
        w_bo        = w_res[BLOCK];
        w_last      = (r_k == KW'(NBLK - 1));
        w_diff_next = r_diff;
        w_diff_next[int'(r_k)*BLOCK +: BLOCK] = w_res[BLOCK-1:0];
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_a          <= {WIDTH{1'b0}};
            r_b          <= {WIDTH{1'b0}};
            r_br         <= 1'b0;
            r_k          <= {KW{1'b0}};
            r_diff       <= {WIDTH{1'b0}};
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
            r_skip_count <= {SCW{1'b0}};
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a          <= a;
                        r_b          <= b;
                        r_br         <= borrow_in;
                        r_k          <= {KW{1'b0}};
                        r_skip_count <= {SCW{1'b0}};
                        r_in_ready   <= 1'b0;
                        r_state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_diff <= w_diff_next;
                    r_br   <= w_bo;
                    if (w_skip) begin
                        r_skip_count <= r_skip_count + SCW'(1);
                    end
                    if (w_last) begin
                        r_borrow_out <= w_bo;
                        r_overflow   <= (r_a[MSB] != r_b[MSB]) && (w_diff_next[MSB] != r_a[MSB]);
                        r_out_valid  <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;
    assign skip_count = r_skip_count;
endmodule

// File: tb/tb_borrow_skip_subtractor_seq.sv
// Directed and randomized self-checking bench for borrow_skip_subtractor_seq (WIDTH=16, BLOCK=4).
module tb_borrow_skip_subtractor_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow_out;
    logic        overflow;
    logic [2:0]  skip_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    borrow_skip_subtractor_seq #(.WIDTH(16), .BLOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out), .overflow(overflow), .skip_count(skip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [15:0] VA [4] = '{16'h1234, 16'h0000, 16'h8000, 16'h5555};
    localparam logic [15:0] VB [4] = '{16'h1234, 16'h0001, 16'h0001, 16'h5555};
    localparam logic        VI [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [15:0] VD [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'hFFFF};
    localparam logic        VBO[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic        VOV[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [2:0]  VSC[4] = '{3'd4, 3'd3, 3'd2, 3'd4};

    // Reference: arithmetic difference, slice-equality skip count, signed overflow rule.
    function automatic logic [20:0] ref_calc(input logic [15:0] ra, input logic [15:0] rb, input logic rbin);
        logic [16:0] full;
        logic [2:0]  sc;
        logic        ov;
        full = {1'b0, ra} - {1'b0, rb} - {16'h0000, rbin};
        sc   = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (ra[k*4 +: 4] == rb[k*4 +: 4]) sc = sc + 3'd1;
        end
        ov = (ra[15] != rb[15]) && (full[15] != ra[15]);
        return {sc, ov, full[16], full[15:0]};
    endfunction

    // Presents operands until the edge that accepts them; returns the accepting cycle.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin, output int acc_cyc);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            errors++; checks++;
            $display("FAIL start_op: in_ready=%0b required 1 within 20 cycles", in_ready);
        end
        a = ta; b = tb; borrow_in = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; borrow_in = 1'b1;
    endtask

    // Counts edges after acceptance until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (diff !== 16'h0000)   begin errors++; $display("FAIL rst_diff: got %h want 0000", diff); end
        checks++; if ({borrow_out, overflow, skip_count} !== 5'b0) begin
            errors++; $display("FAIL rst_flags: got bo=%b ov=%b sc=%0d want 0", borrow_out, overflow, skip_count);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        int acc, lat;
        for (int v = 0; v < 4; v++) begin
            out_ready = 1'b0;
            start_op(VA[v], VB[v], VI[v], acc);
            wait_valid(lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL vec%0d_latency: got %0d want 4", v, lat); end
            checks++; if (diff !== VD[v]) begin errors++; $display("FAIL vec%0d_diff: got %h want %h", v, diff, VD[v]); end
            checks++; if (borrow_out !== VBO[v]) begin errors++; $display("FAIL vec%0d_borrow: got %b want %b", v, borrow_out, VBO[v]); end
            checks++; if (overflow !== VOV[v]) begin errors++; $display("FAIL vec%0d_overflow: got %b want %b", v, overflow, VOV[v]); end
            checks++; if (skip_count !== VSC[v]) begin errors++; $display("FAIL vec%0d_skip: got %0d want %0d", v, skip_count, VSC[v]); end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checks++; if ({out_valid, in_ready} !== 2'b01) begin
                errors++; $display("FAIL vec%0d_release: got ov=%b ir=%b want 0 1", v, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc, lat;
        out_ready = 1'b0;
        start_op(16'hA5A5, 16'h5A5A, 1'b0, acc);
        wait_valid(lat);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin a = 16'h0001; b = 16'h0002; borrow_in = 1'b0; in_valid = 1'b1; end
            else in_valid = 1'b0;
            checks++;
            if ({out_valid, in_ready, diff, borrow_out, overflow, skip_count} !== {1'b1, 1'b0, 16'h4B4B, 1'b0, 1'b1, 3'd0}) begin
                errors++;
                $display("FAIL bp_hold%0d: got ov=%b ir=%b d=%h bo=%b of=%b sc=%0d want 1 0 4b4b 0 1 0",
                         c, out_valid, in_ready, diff, borrow_out, overflow, skip_count);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release: got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        start_op(16'h0003, 16'h0001, 1'b0, acc);
        wait_valid(lat);
        checks++; if ({diff, borrow_out, skip_count} !== {16'h0002, 1'b0, 3'd3}) begin
            errors++; $display("FAIL bp_next: got d=%h bo=%b sc=%0d want 0002 0 3", diff, borrow_out, skip_count);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, lat;
        out_ready = 1'b1;
        start_op(16'h0010, 16'h0001, 1'b1, acc1);
        wait_valid(lat);
        checks++; if ({diff, borrow_out, overflow, skip_count} !== {16'h000E, 1'b0, 1'b0, 3'd2}) begin
            errors++; $display("FAIL b2b_first: got d=%h bo=%b of=%b sc=%0d want 000e 0 0 2", diff, borrow_out, overflow, skip_count);
        end
        @(posedge clk); #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL b2b_one_cycle: got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        start_op(16'h7FFF, 16'hFFFF, 1'b0, acc2);
        checks++; if (acc2 - acc1 !== 6) begin
            errors++; $display("FAIL b2b_throughput: got %0d cycles want 6", acc2 - acc1);
        end
        wait_valid(lat);
        checks++; if ({diff, borrow_out, overflow, skip_count} !== {16'h8000, 1'b1, 1'b1, 3'd3}) begin
            errors++; $display("FAIL b2b_second: got d=%h bo=%b of=%b sc=%0d want 8000 1 1 3", diff, borrow_out, overflow, skip_count);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int acc;
        out_ready = 1'b0;
        start_op(16'hFFFF, 16'h0001, 1'b0, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, diff, borrow_out, overflow, skip_count} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL midrun_reset: got ir=%b ov=%b d=%h bo=%b of=%b sc=%0d want 1 0 0000 0 0 0",
                     in_ready, out_valid, diff, borrow_out, overflow, skip_count);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL midrun_release: got ir=%b ov=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        logic [20:0] expv;
        logic        acc, pend, prev_ov;
        logic [15:0] ca, cb;
        logic        cbin;
        int          lat, done_ops, n;
        pend = 1'b0; prev_ov = out_valid; lat = 0; done_ops = 0; n = 0;
        expv = 21'd0;
        while (done_ops < 2000 && n < 40000) begin
            ca = 16'($urandom);
            cb = ca;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1) cb[k*4 +: 4] = 4'($urandom);
            end
            cbin      = 1'($urandom);
            a         = ca; b = cb; borrow_in = cbin;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
            acc       = in_ready && in_valid;
            @(posedge clk); #1;
            n++;
            if (acc) begin
                expv = ref_calc(ca, cb, cbin);
                pend = 1'b1;
                lat  = 0;
            end else if (pend) begin
                lat++;
            end
            if (out_valid && !prev_ov) begin
                checks++;
                if (!pend || lat != 4 || {skip_count, overflow, borrow_out, diff} !== expv) begin
                    errors++;
                    $display("FAIL rand_op%0d: got sc=%0d of=%b bo=%b d=%h lat=%0d want sc=%0d of=%b bo=%b d=%h lat=4",
                             done_ops, skip_count, overflow, borrow_out, diff, lat,
                             expv[20:18], expv[17], expv[16], expv[15:0]);
                end
                pend = 1'b0;
                done_ops++;
            end
            prev_ov = out_valid;
        end
        in_valid = 1'b0;
        checks++; if (done_ops < 2000) begin
            errors++; $display("FAIL rand_progress: got %0d ops want 2000", done_ops);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; a = 16'h0000; b = 16'h0000; borrow_in = 1'b0; rst_n = 1'b1;
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
